aes_subbytes_pipe: RTL and testbench

Parametrised, pipelined SubBytes engine for the AES-256 datapath. It applies the byte substitution to `LANES` bytes per beat, in parallel, and selects forward or inverse substitution per beat. A valid/ready handshake lets it sit between the round-key XOR stage and ShiftRows, in either the encrypt or decrypt path. It replaces the single-byte combinational `sbox` lookup wherever a registered, flow-controlled multi-byte substitution is needed.

---
 rtl/aes_subbytes_pipe.sv | 159 +++++++++++++++
 tb/tb_aes_subbytes_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_pipe.sv
// Pipelined multi-lane AES SubBytes stage (forward/inverse) with valid/ready flow control.
// Define AES_SBOX_INV_EN to build inverse tables; otherwise in_inv is only carried to out_inv.
module aes_subbytes_pipe #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv
);

    localparam int unsigned W = 8 * LANES;

    if (LANES < 1 || LANES > 16 || (STAGES != 1 && STAGES != 2)) begin : g_bad_param
        $error("aes_subbytes_pipe: LANES must be 1..16 and STAGES 1 or 2");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] t;
        logic [7:0] s;
        t = gf_inv(b);
        for (int i = 0; i < 8; i++) begin
            s[i] = t[i] ^ t[(i + 4) % 8] ^ t[(i + 5) % 8] ^ t[(i + 6) % 8] ^ t[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(t ^ 8'h05);
    endfunction
`endif

    logic [W-1:0] sub_src;
    logic         sub_mode;
    logic [W-1:0] sub_out;

    always_comb begin
        sub_out = '0;
        for (int l = 0; l < int'(LANES); l++) begin
`ifdef AES_SBOX_INV_EN
            sub_out[8*l +: 8] = sub_mode ? inv_sbox(sub_src[8*l +: 8])
                                         : fwd_sbox(sub_src[8*l +: 8]);
`else
            sub_out[8*l +: 8] = fwd_sbox(sub_src[8*l +: 8]);
`endif
        end
    end

    if (STAGES == 2) begin : g_two_stage
        logic         v1_q, v2_q;
        logic         m1_q, m2_q;
        logic [W-1:0] d1_q, d2_q;
        logic         adv_last;

        // Stage 1 holds the raw beat; the lookup sits between stage 1 and stage 2.
        assign sub_src   = d1_q;
        assign sub_mode  = m1_q;
        assign adv_last  = !v2_q || out_ready;
        assign in_ready  = !rst && (!v1_q || adv_last);
        assign out_valid = v2_q;
        assign out_data  = d2_q;
        assign out_inv   = m2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
                m1_q <= 1'b0;
                m2_q <= 1'b0;
                d1_q <= '0;
                d2_q <= '0;
            end else begin
                if (in_valid && in_ready) begin
                    v1_q <= 1'b1;
                    d1_q <= in_data;
                    m1_q <= in_inv;
                end else if (adv_last) begin
                    v1_q <= 1'b0;
                end
                if (adv_last) begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= sub_out;
                        m2_q <= m1_q;
                    end
                end
            end
        end
    end else begin : g_one_stage
        logic         v_q;
        logic         m_q;
        logic [W-1:0] d_q;
        logic         adv_last;

        assign sub_src   = in_data;
        assign sub_mode  = in_inv;
        assign adv_last  = !v_q || out_ready;
        assign in_ready  = !rst && adv_last;
        assign out_valid = v_q;
        assign out_data  = d_q;
        assign out_inv   = m_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                m_q <= 1'b0;
                d_q <= '0;
            end else if (adv_last) begin
                v_q <= in_valid;
                if (in_valid) begin
                    d_q <= sub_out;
                    m_q <= in_inv;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Self-checking bench for aes_subbytes_pipe: directed cases plus random valid/ready traffic,
// scored against S-box tables generated independently from the GF(2^8) generator walk.
`define TB_CHECK(tag, obs, exp) \
    begin \
        n_chk++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
        end \
    end

module tb_aes_subbytes_pipe;

    localparam int unsigned LANES  = 16;
    localparam int unsigned STAGES = 2;
    localparam int unsigned W      = 8 * LANES;
    localparam int unsigned NRAND  = 10000;
`ifdef AES_SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_inv;

    aes_subbytes_pipe #(
        .LANES (LANES),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_inv  (out_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         inv;
        logic [W-1:0] data;
    } beat_t;

    int      n_chk = 0;
    int      n_fail = 0;
    int      n_pushed = 0;
    int      n_popped = 0;
    int      n_dropped = 0;
    bit [7:0] sbox[256];
    bit [7:0] isbox[256];
    beat_t   exp_q[$];

    function automatic bit [7:0] rotl(bit [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Walk p over the multiplicative group via generator 3 and q over its inverse (generator 0xf6).
    task automatic build_tables();
        bit [7:0] p;
        bit [7:0] q;
        bit [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [W-1:0] ref_sub(logic [W-1:0] d, logic inv);
        logic [W-1:0] r;
        for (int l = 0; l < int'(LANES); l++) begin
            r[8*l +: 8] = (INV_EN && inv) ? isbox[d[8*l +: 8]] : sbox[d[8*l +: 8]];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] r;
        for (int l = 0; l < int'(LANES); l++) r[8*l +: 8] = 8'($urandom);
        return r;
    endfunction

    // Scoreboard: handshakes are sampled at the falling edge and take effect on the next rise.
    logic  stall_prev = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            n_dropped += exp_q.size();
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) `TB_CHECK("stall_hold", {out_valid, out_inv, out_data}, {1'b1, held})
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $error("FAIL unexpected_beat: observed %0h expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    `TB_CHECK("out_beat", {out_inv, out_data}, e)
                    n_popped++;
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back({in_inv, ref_sub(in_data, in_inv)});
                n_pushed++;
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            held       = {out_inv, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(string tag, logic [31:0] lo, logic inv, logic [31:0] exp_lo);
        tick();
        in_valid      = 1'b1;
        in_inv        = inv;
        in_data       = rand_data();
        in_data[31:0] = lo;
        @(negedge clk);
        `TB_CHECK(tag, in_ready, 1'b1)
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < int'(STAGES); i++) begin
            @(negedge clk);
            `TB_CHECK(tag, out_valid, 1'b0)
            tick();
        end
        @(negedge clk);
        `TB_CHECK(tag, out_valid, 1'b1)
        `TB_CHECK(tag, out_data[31:0], exp_lo)
        `TB_CHECK(tag, out_inv, inv)
        tick();
    endtask

    initial begin
        int acc;
        int sent;
        int cyc;
        int pop0;
        bit acc_prev;

        build_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        `TB_CHECK("reset_out_valid", out_valid, 1'b0)
        `TB_CHECK("reset_out_data", out_data, {W{1'b0}})
        `TB_CHECK("reset_out_inv", out_inv, 1'b0)
        `TB_CHECK("reset_in_ready", in_ready, 1'b1)

        // Directed lookups with fixed latency.
        out_ready = 1'b1;
        single_beat("fwd_known", 32'h01ff5300, 1'b0, 32'h7c16ed63);
        single_beat("inv_known", 32'h7c16ed63, 1'b1, INV_EN ? 32'h01ff5300 : 32'h104755fb);

        // Backpressure: fill the pipe, hold, then release.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_data();
        in_inv    = ($urandom % 2) == 1;
        acc       = 0;
        for (int c = 0; c < 10 && acc < int'(STAGES); c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
            in_data = rand_data();
            in_inv  = ($urandom % 2) == 1;
        end
        `TB_CHECK("bp_accepts", acc, int'(STAGES))
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            `TB_CHECK("bp_full", in_ready, 1'b0)
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        `TB_CHECK("bp_recover", in_ready, 1'b1)
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        `TB_CHECK("bp_drain", exp_q.size(), 0)

        // Streaming: every byte value through every lane, alternating mode.
        pop0 = n_popped;
        for (int k = 0; k < 256; k++) begin
            tick();
            in_valid = 1'b1;
            in_inv   = (k % 2) == 1;
            for (int l = 0; l < int'(LANES); l++) in_data[8*l +: 8] = 8'((k + 16 * l) % 256);
            @(negedge clk);
            `TB_CHECK("stream_ready", in_ready, 1'b1)
            if (k >= int'(STAGES)) `TB_CHECK("stream_out_valid", out_valid, 1'b1)
        end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        `TB_CHECK("stream_count", n_popped - pop0, 256)

        // Reset with beats in flight; a beat is also offered during the reset cycle.
        out_ready = 1'b0;
        for (int k = 0; k < int'(STAGES); k++) begin
            tick();
            in_valid = 1'b1;
            in_data  = rand_data();
            in_inv   = ($urandom % 2) == 1;
        end
        tick();
        rst     = 1'b1;
        in_data = rand_data();
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        `TB_CHECK("midrst_out_valid", out_valid, 1'b0)
        `TB_CHECK("midrst_out_data", out_data, {W{1'b0}})
        repeat (8) tick();

        // Random valid/ready traffic; valid is held with stable data until accepted.
        sent     = 0;
        cyc      = 0;
        acc_prev = 1'b0;
        while (sent < int'(NRAND) && cyc < 60000) begin
            tick();
            cyc++;
            if (!in_valid || acc_prev) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = rand_data();
                in_inv   = ($urandom % 2) == 1;
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc_prev = in_valid && in_ready;
            if (acc_prev) sent++;
        end
        `TB_CHECK("rand_sent", sent, int'(NRAND))
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        `TB_CHECK("rand_drain", exp_q.size(), 0)
        `TB_CHECK("conservation", n_popped + n_dropped, n_pushed)

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`undef TB_CHECK
